// File: rtl/systolic_feeder.sv
// Feeder for a weight-stationary systolic array: shifts weight rows down the columns,
// streams skewed input vectors into the rows, then drains the array with zeros.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [COLS*DATA_WIDTH-1:0] w_data,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] x_data,
  input  logic                       x_last,
  output logic [1:0]                 mode_ctrl,
  output logic [COLS*DATA_WIDTH-1:0] arr_top,
  output logic [ROWS*DATA_WIDTH-1:0] arr_left,
  output logic                       busy,
  output logic                       done
);

  localparam int WCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DCW = $clog2(ROWS + COLS);
  localparam logic [WCW-1:0] W_LAST = WCW'(ROWS - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(ROWS + COLS - 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  state_t                     state_q;
  logic [WCW-1:0]             wcnt_q;
  logic [DCW-1:0]             dcnt_q;
  logic [1:0]                 mode_q;
  logic [COLS*DATA_WIDTH-1:0] top_q;
  logic                       done_q;
  logic                       adv;
  logic [ROWS*DATA_WIDTH-1:0] skew_in;

  assign w_ready   = (state_q == S_LOAD);
  assign x_ready   = (state_q == S_COMPUTE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign mode_ctrl = mode_q;
  assign arr_top   = top_q;

  // Skew only moves when the array computes, so stalls freeze every in-flight element.
  assign adv     = (state_q == S_DRAIN) || ((state_q == S_COMPUTE) && x_valid);
  assign skew_in = (state_q == S_COMPUTE) ? x_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
      mode_q  <= 2'b00;
      top_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          mode_q <= 2'b00;
          top_q  <= '0;
          if (start) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (w_valid) begin
            top_q  <= w_data;
            mode_q <= 2'b01;
            if (wcnt_q == W_LAST) begin
              wcnt_q  <= '0;
              state_q <= S_COMPUTE;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end else begin
            mode_q <= 2'b00;
          end
        end
        S_COMPUTE: begin
          top_q <= '0;
          if (x_valid) begin
            mode_q <= 2'b10;
            if (x_last) begin
              dcnt_q  <= '0;
              state_q <= S_DRAIN;
            end
          end else begin
            mode_q <= 2'b00;
          end
        end
        S_DRAIN: begin
          top_q  <= '0;
          mode_q <= 2'b10;
          if (dcnt_q == D_LAST) begin
            dcnt_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Row r carries r+1 stages so element r lands r advances after element 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] stg_q [r+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) stg_q[i] <= '0;
      end else if (adv) begin
        stg_q[0] <= skew_in[r*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i <= r; i++) stg_q[i] <= stg_q[i-1];
      end
    end

    assign arr_left[r*DATA_WIDTH +: DATA_WIDTH] = stg_q[r];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed table-driven bench for systolic_feeder (ROWS=COLS=4, 8-bit elements).
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, w_valid = 1'b0, x_valid = 1'b0, x_last = 1'b0;
  logic [31:0] w_data = '0, x_data = '0;
  logic        w_ready, x_ready, busy, done;
  logic [1:0]  mode_ctrl;
  logic [31:0] arr_top, arr_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_WIDTH(8), .ROWS(4), .COLS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .mode_ctrl(mode_ctrl), .arr_top(arr_top), .arr_left(arr_left),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic        s, wv, xv, xl;
    logic [31:0] wd, xd;
    logic [1:0]  mode;
    logic [31:0] top, left;
    logic        wr, xr, bsy, dn;
  } vec_t;

  vec_t tbl[$];
  int   n1;

  function automatic vec_t mk(input logic s, input logic wv, input logic [31:0] wd,
                              input logic xv, input logic [31:0] xd, input logic xl,
                              input logic [1:0] mode, input logic [31:0] top,
                              input logic [31:0] left, input logic wr, input logic xr,
                              input logic bsy, input logic dn);
    vec_t v;
    v.s = s; v.wv = wv; v.wd = wd; v.xv = xv; v.xd = xd; v.xl = xl;
    v.mode = mode; v.top = top; v.left = left;
    v.wr = wr; v.xr = xr; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  task automatic check_outs(input int step, input logic [1:0] m, input logic [31:0] t,
                            input logic [31:0] l, input logic wr, input logic xr,
                            input logic b, input logic d);
    chk("mode_ctrl", step, 32'(mode_ctrl), 32'(m));
    chk("arr_top",   step, arr_top, t);
    chk("arr_left",  step, arr_left, l);
    chk("w_ready",   step, 32'(w_ready), 32'(wr));
    chk("x_ready",   step, 32'(x_ready), 32'(xr));
    chk("busy",      step, 32'(busy), 32'(b));
    chk("done",      step, 32'(done), 32'(d));
  endtask

  task automatic apply(input int i);
    start = tbl[i].s; w_valid = tbl[i].wv; w_data = tbl[i].wd;
    x_valid = tbl[i].xv; x_data = tbl[i].xd; x_last = tbl[i].xl;
    @(posedge clk);
    #1;
    check_outs(i, tbl[i].mode, tbl[i].top, tbl[i].left, tbl[i].wr, tbl[i].xr,
               tbl[i].bsy, tbl[i].dn);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
    start = 0; w_valid = 0; x_valid = 0; x_last = 0; w_data = '0; x_data = '0;
  endtask

  initial begin
    // Pass A: back-to-back weights and vectors; start pulses in LOAD and DRAIN are ignored.
    tbl.push_back(mk(1,0,32'h0,       0,32'h0,0, 2'b00,32'h0,       32'h0,        1,0,1,0));
    tbl.push_back(mk(0,1,32'h01010101,0,32'h0,0, 2'b01,32'h01010101,32'h0,        1,0,1,0));
    tbl.push_back(mk(1,1,32'h02020202,0,32'h0,0, 2'b01,32'h02020202,32'h0,        1,0,1,0));
    tbl.push_back(mk(0,1,32'h03030303,0,32'h0,0, 2'b01,32'h03030303,32'h0,        1,0,1,0));
    tbl.push_back(mk(0,1,32'h04040404,0,32'h0,0, 2'b01,32'h04040404,32'h0,        0,1,1,0));
    tbl.push_back(mk(0,0,32'h0,1,32'h04030201,0, 2'b10,32'h0,       32'h00000001, 0,1,1,0));
    tbl.push_back(mk(0,0,32'h0,1,32'h08070605,1, 2'b10,32'h0,       32'h00000205, 0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h00030600, 0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h04070000, 0,0,1,0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h08000000, 0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0,        0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0,        0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0,        0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0,        0,0,0,1));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b00,32'h0,       32'h0,        0,0,0,0));
    n1 = tbl.size();
    // Pass B: w_valid toggling in LOAD, 3-cycle x stall with junk data, three vectors.
    tbl.push_back(mk(1,0,32'h0,       0,32'h0,0, 2'b00,32'h0,       32'h0,        1,0,1,0));
    tbl.push_back(mk(0,1,32'h11111111,0,32'h0,0, 2'b01,32'h11111111,32'h0,        1,0,1,0));
    tbl.push_back(mk(0,0,32'h22222222,0,32'h0,0, 2'b00,32'h11111111,32'h0,        1,0,1,0));
    tbl.push_back(mk(0,1,32'h22222222,0,32'h0,0, 2'b01,32'h22222222,32'h0,        1,0,1,0));
    tbl.push_back(mk(0,0,32'h0,       0,32'h0,0, 2'b00,32'h22222222,32'h0,        1,0,1,0));
    tbl.push_back(mk(0,1,32'h33333333,0,32'h0,0, 2'b01,32'h33333333,32'h0,        1,0,1,0));
    tbl.push_back(mk(0,0,32'h0,       0,32'h0,0, 2'b00,32'h33333333,32'h0,        1,0,1,0));
    tbl.push_back(mk(0,1,32'h44444444,0,32'h0,0, 2'b01,32'h44444444,32'h0,        0,1,1,0));
    tbl.push_back(mk(0,0,32'h0,1,32'h04030201,0, 2'b10,32'h0,       32'h00000001, 0,1,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'hFFFFFFFF,1, 2'b00,32'h0,       32'h00000001, 0,1,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'hFFFFFFFF,1, 2'b00,32'h0,       32'h00000001, 0,1,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'hFFFFFFFF,1, 2'b00,32'h0,       32'h00000001, 0,1,1,0));
    tbl.push_back(mk(0,0,32'h0,1,32'h08070605,0, 2'b10,32'h0,       32'h00000205, 0,1,1,0));
    tbl.push_back(mk(0,0,32'h0,1,32'h0C0B0A09,1, 2'b10,32'h0,       32'h00030609, 0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h04070A00, 0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h080B0000, 0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0C000000, 0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0,        0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0,        0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0,        0,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b10,32'h0,       32'h0,        0,0,0,1));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,        2'b00,32'h0,       32'h0,        0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    check_outs(-1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0);
    #1 rst = 1'b0;

    run_range(0, n1 - 1);
    run_range(n1, tbl.size() - 1);

    // Reset mid-COMPUTE after two vectors, then a clean pass.
    run_range(0, 5);
    x_valid = 1; x_data = 32'h08070605; x_last = 0;
    @(posedge clk);
    #1;
    check_outs(100, 2'b10, 32'h0, 32'h00000205, 0, 1, 1, 0);
    x_valid = 0; x_data = '0;
    #2 rst = 1'b1;
    #1;
    check_outs(101, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs(102, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    run_range(0, n1 - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
